// File: rtl/baud_rate_generator_frac.sv
// Fractional baud generator: oversample, mid-bit and bit ticks from one clock; all outputs registered (1 clk).
// No backpressure: en freezes the phase; cfg_load and resync restart it.
module baud_rate_generator_frac #(
    parameter int DIV_INT_W    = 16,
    parameter int DIV_FRAC_W   = 4,
    parameter int OS_W         = 5,
    parameter int DEF_DIV_INT  = 325,
    parameter int DEF_DIV_FRAC = 8,
    parameter int DEF_OS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  cfg_load,
    input  logic [DIV_INT_W-1:0]  div_int,
    input  logic [DIV_FRAC_W-1:0] div_frac,
    input  logic [OS_W-1:0]       os_rate,
    input  logic                  resync,
    output logic                  os_tick,
    output logic                  mid_tick,
    output logic                  bit_tick,
    output logic                  cfg_err
);

    localparam logic [OS_W-1:0] OS_ONE = {{(OS_W-1){1'b0}}, 1'b1};

    logic [DIV_INT_W-1:0]  div_int_q;
    logic [DIV_FRAC_W-1:0] div_frac_q;
    logic [OS_W-1:0]       os_rate_q;

    logic [DIV_INT_W-1:0]  cnt;
    logic [DIV_FRAC_W-1:0] acc;
    logic                  ext;
    logic [OS_W-1:0]       os_cnt;

    logic                  cfg_ok;
    logic [DIV_INT_W:0]    term;
    logic                  term_hit;
    logic [DIV_FRAC_W:0]   acc_sum;
    logic [OS_W-1:0]       mid_pt;
    logic                  os_wrap;

    assign cfg_ok   = (div_int >= DIV_INT_W'(2)) && (os_rate >= OS_W'(4));
    // ext stretches the current period by one clock when the fractional accumulator carried
    assign term     = {1'b0, div_int_q} - {{DIV_INT_W{1'b0}}, 1'b1} + {{DIV_INT_W{1'b0}}, ext};
    assign term_hit = ({1'b0, cnt} == term);
    assign acc_sum  = {1'b0, acc} + {1'b0, div_frac_q};
    assign mid_pt   = (os_rate_q >> 1) - OS_ONE;
    assign os_wrap  = (os_cnt == os_rate_q - OS_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_int_q  <= DIV_INT_W'(DEF_DIV_INT);
            div_frac_q <= DIV_FRAC_W'(DEF_DIV_FRAC);
            os_rate_q  <= OS_W'(DEF_OS);
            cnt        <= '0;
            acc        <= '0;
            ext        <= 1'b0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            mid_tick   <= 1'b0;
            bit_tick   <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
            if (cfg_load && cfg_ok) begin
                div_int_q  <= div_int;
                div_frac_q <= div_frac;
                os_rate_q  <= os_rate;
                cnt        <= '0;
                acc        <= '0;
                ext        <= 1'b0;
                os_cnt     <= '0;
                cfg_err    <= 1'b0;
            end else begin
                if (cfg_load) begin
                    cfg_err <= 1'b1;
                end
                // resync also swallows a tick that would land on this edge
                if (resync) begin
                    cnt    <= '0;
                    acc    <= '0;
                    ext    <= 1'b0;
                    os_cnt <= '0;
                end else if (en) begin
                    if (term_hit) begin
                        cnt        <= '0;
                        {ext, acc} <= acc_sum;
                        os_tick    <= 1'b1;
                        mid_tick   <= (os_cnt == mid_pt);
                        bit_tick   <= os_wrap;
                        os_cnt     <= os_wrap ? '0 : os_cnt + OS_ONE;
                    end else begin
                        cnt <= cnt + {{(DIV_INT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_rate_generator_frac.sv
// Bench for baud_rate_generator_frac: directed scenarios plus random traffic, each cycle checked against
// a closed-form model where tick n after a restart lands n*div_int + floor((n-1)*div_frac/16) enabled clocks in.
module tb_baud_rate_generator_frac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic [4:0]  os_rate = '0;
    logic        resync = 1'b0;
    logic        os_tick, mid_tick, bit_tick, cfg_err;

    baud_rate_generator_frac dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
        .div_int(div_int), .div_frac(div_frac), .os_rate(os_rate), .resync(resync),
        .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mark     = 0;
    int os_q[$];
    int mid_q[$];
    int bit_q[$];

    longint m_d, m_f, m_os, m_e, m_n;
    bit     m_err;
    bit     x_os, x_mid, x_bit;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        x_os = 1'b0; x_mid = 1'b0; x_bit = 1'b0;
        if (rst) begin
            m_d = 325; m_f = 8; m_os = 16; m_e = 0; m_n = 0; m_err = 1'b0;
        end else if (cfg_load && div_int >= 2 && os_rate >= 4) begin
            m_d = longint'(div_int); m_f = longint'(div_frac); m_os = longint'(os_rate);
            m_e = 0; m_n = 0; m_err = 1'b0;
        end else begin
            if (cfg_load) m_err = 1'b1;
            if (resync) begin
                m_e = 0; m_n = 0;
            end else if (en) begin
                m_e++;
                if (m_e == (m_n + 1) * m_d + (m_n * m_f) / 16) begin
                    m_n++;
                    x_os  = 1'b1;
                    x_mid = (m_n % m_os) == (m_os / 2);
                    x_bit = (m_n % m_os) == 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("os_tick", os_tick, x_os);
        chk("mid_tick", mid_tick, x_mid);
        chk("bit_tick", bit_tick, x_bit);
        chk("cfg_err", cfg_err, m_err);
        if (os_tick === 1'b1)  os_q.push_back(cyc);
        if (mid_tick === 1'b1) mid_q.push_back(cyc);
        if (bit_tick === 1'b1) bit_q.push_back(cyc);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic restart_marks();
        mark = cyc;
        os_q.delete(); mid_q.delete(); bit_q.delete();
    endtask

    task automatic load(input int di, input int df, input int os, input bit rs);
        div_int = 16'(di); div_frac = 4'(df); os_rate = 5'(os);
        cfg_load = 1'b1; resync = rs;
        step();
        cfg_load = 1'b0; resync = 1'b0;
        restart_marks();
    endtask

    initial begin
        // reset state
        run(3);
        rst = 1'b0;
        en  = 1'b1;

        // T1: integer divisor 4, oversample 4
        load(4, 0, 4, 1'b0);
        run(40);
        chk_int("t1_first_os", os_q[0] - mark, 4);
        for (int i = 1; i < 8; i++) chk_int("t1_os_period", os_q[i] - os_q[i-1], 4);
        chk_int("t1_first_mid", mid_q[0] - mark, 8);
        chk_int("t1_first_bit", bit_q[0] - mark, 16);
        chk_int("t1_bit_period", bit_q[1] - bit_q[0], 16);

        // T2: fractional half-clock
        load(4, 8, 16, 1'b0);
        run(100);
        chk_int("t2_p1", os_q[0] - mark, 4);
        chk_int("t2_p2", os_q[1] - os_q[0], 4);
        chk_int("t2_p3", os_q[2] - os_q[1], 5);
        chk_int("t2_p4", os_q[3] - os_q[2], 4);
        chk_int("t2_16_periods", os_q[17] - os_q[1], 72);

        // T3: defaults after reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        restart_marks();
        run(10450);
        chk_int("t3_first_os", os_q[0] - mark, 325);
        chk_int("t3_p2", os_q[1] - os_q[0], 325);
        chk_int("t3_p3", os_q[2] - os_q[1], 326);
        chk_int("t3_16_ticks", os_q[16] - os_q[0], 5208);
        chk_int("t3_first_mid", mid_q[0] - mark, 2603);
        chk_int("t3_first_bit", bit_q[0] - mark, 5207);
        chk_int("t3_bit_period", bit_q[1] - bit_q[0], 5208);

        // T4: resync in the middle of a bit
        load(4, 0, 16, 1'b0);
        run(50);
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("t4_no_tick_after_resync", os_tick, 1'b0);
        restart_marks();
        run(80);
        chk_int("t4_first_os", os_q[0] - mark, 4);
        chk_int("t4_first_mid", mid_q[0] - mark, 32);
        chk_int("t4_first_bit", bit_q[0] - mark, 64);

        // T5: illegal loads keep running config, legal load with resync restarts once
        load(1, 0, 16, 1'b0);
        chk("t5_err_div", cfg_err, 1'b1);
        run(20);
        chk_int("t5_period_kept", os_q[1] - os_q[0], 4);
        load(4, 0, 3, 1'b0);
        chk("t5_err_os", cfg_err, 1'b1);
        load(5, 3, 8, 1'b1);
        chk("t5_err_clear", cfg_err, 1'b0);
        run(30);
        chk_int("t5_first_os", os_q[0] - mark, 5);

        // T6: enable freeze mid-period, then reset mid-bit
        load(4, 0, 8, 1'b0);
        run(6);
        en = 1'b0;
        run(10);
        chk_int("t6_ticks_frozen", os_q.size(), 1);
        en = 1'b1;
        run(10);
        chk_int("t6_resume", os_q[1] - mark, 18);
        run(20);
        rst = 1'b1;
        step();
        chk("t6_rst_os", os_tick, 1'b0);
        chk("t6_rst_bit", bit_tick, 1'b0);
        rst = 1'b0;
        restart_marks();
        run(330);
        chk_int("t6_default_restored", os_q[0] - mark, 325);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(9) != 0);
            resync   = ($urandom_range(63) == 0);
            cfg_load = ($urandom_range(127) == 0);
            rst      = ($urandom_range(999) == 0);
            div_int  = 16'($urandom_range(8));
            div_frac = 4'($urandom);
            os_rate  = 5'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
